// File: rtl/mem_dump_sequencer_pkg.sv
// Shared definitions for the memory-dump address sequencer.
// State encodings stay plain localparams so legacy mux logic can decode them directly.
package mem_dump_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_MANUAL = 2'd1;
  localparam state_t ST_AUTO   = 2'd2;

  localparam int          DEF_ADDR_W   = 16;
  localparam logic [15:0] DEF_DUMP_LO  = 16'h0000;
  localparam logic [15:0] DEF_DUMP_HI  = 16'h00FF;
  localparam int          DEF_AUTO_DIV = 25_000_000;

endpackage

// File: rtl/mem_dump_sequencer_if.sv
// Bundle between the dump sequencer (master) and the dump/processor address mux (slave).
interface mem_dump_sequencer_if
  import mem_dump_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              enable;
  logic              step_in;
  logic              auto_mode;
  logic              dir;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              rd_strobe;
  logic              wrap;
  logic              busy;

  modport master (
    input  enable, step_in, auto_mode, dir,
    output addr, addr_valid, rd_strobe, wrap, busy
  );

  modport slave (
    output enable, step_in, auto_mode, dir,
    input  addr, addr_valid, rd_strobe, wrap, busy
  );

endinterface

// File: rtl/mem_dump_sequencer_step_sync_edge.sv
// Three-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
// Meant for any debounced front-panel button, not just the dump step key.
module step_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchronizer chain; s3 only serves as the delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign pulse = s2_r & ~s3_r;

endmodule

// File: rtl/mem_dump_sequencer.sv
// Bounded dump-address sequencer: manual step or auto-run, up/down, wrapping inside
// [DUMP_LO, DUMP_HI], with a strobe whenever the address changes.
module mem_dump_sequencer
  import mem_dump_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] DUMP_LO  = ADDR_W'(DEF_DUMP_LO),
  parameter logic [ADDR_W-1:0] DUMP_HI  = ADDR_W'(DEF_DUMP_HI),
  parameter int                AUTO_DIV = DEF_AUTO_DIV
) (
  input logic                  clk,
  input logic                  reset,
  mem_dump_sequencer_if.master bus
);

  localparam int                TICK_W    = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_DIV - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_nxt_s;
  logic              strobe_nxt_s;
  logic              wrap_nxt_s;
  logic              rd_strobe_r;
  logic              wrap_r;
  logic              valid_r;
  logic              busy_r;
  logic              step_evt_s;
  logic [ADDR_W:0]   adv_s;

  // Returns {wrapped, next_addr}; the window bounds replace any modular overflow.
  function automatic logic [ADDR_W:0] advance(input logic [ADDR_W-1:0] cur, input logic down);
    logic [ADDR_W:0] res;
    if (down) begin
      if (cur == DUMP_LO) res = {1'b1, DUMP_HI};
      else                res = {1'b0, cur - 1'b1};
    end else begin
      if (cur == DUMP_HI) res = {1'b1, DUMP_LO};
      else                res = {1'b0, cur + 1'b1};
    end
    return res;
  endfunction

  step_sync_edge u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.step_in),
    .pulse (step_evt_s)
  );

  assign adv_s = advance(addr_r, bus.dir);

  // Next-state logic; dropping enable outranks any step or tick in the same cycle.
  always_comb begin
    state_nxt_s  = state_r;
    addr_nxt_s   = addr_r;
    tick_nxt_s   = tick_r;
    strobe_nxt_s = 1'b0;
    wrap_nxt_s   = 1'b0;
    if (!bus.enable) begin
      state_nxt_s = ST_IDLE;
      addr_nxt_s  = DUMP_LO;
      tick_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s  = bus.auto_mode ? ST_AUTO : ST_MANUAL;
          addr_nxt_s   = DUMP_LO;
          tick_nxt_s   = '0;
          strobe_nxt_s = 1'b1;
        end
        ST_MANUAL: begin
          if (bus.auto_mode) begin
            state_nxt_s = ST_AUTO;
            tick_nxt_s  = '0;
          end else if (step_evt_s) begin
            {wrap_nxt_s, addr_nxt_s} = adv_s;
            strobe_nxt_s             = 1'b1;
          end else begin
            state_nxt_s = ST_MANUAL;
          end
        end
        ST_AUTO: begin
          if (!bus.auto_mode) begin
            state_nxt_s = ST_MANUAL;
          end else if (tick_r == TICK_LAST) begin
            tick_nxt_s               = '0;
            {wrap_nxt_s, addr_nxt_s} = adv_s;
            strobe_nxt_s             = 1'b1;
          end else begin
            tick_nxt_s = tick_r + 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          addr_nxt_s  = DUMP_LO;
          tick_nxt_s  = '0;
        end
      endcase
    end
  end

  // State, address and all outputs registered together so they change on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= DUMP_LO;
      tick_r      <= '0;
      rd_strobe_r <= 1'b0;
      wrap_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      tick_r      <= tick_nxt_s;
      rd_strobe_r <= strobe_nxt_s;
      wrap_r      <= wrap_nxt_s;
      valid_r     <= (state_nxt_s != ST_IDLE);
      busy_r      <= (state_nxt_s == ST_AUTO);
    end
  end

  assign bus.addr       = addr_r;
  assign bus.addr_valid = valid_r;
  assign bus.rd_strobe  = rd_strobe_r;
  assign bus.wrap       = wrap_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Directed test-plan scenarios followed by random stimulus, all compared cycle by cycle
// against a window-offset reference model of the dump sequencer.
module tb_mem_dump_sequencer;

  localparam int          ADDR_W   = 16;
  localparam logic [15:0] LO       = 16'h0010;
  localparam logic [15:0] HI       = 16'h0013;
  localparam int          AUTO_DIV = 4;
  localparam int          SPAN     = 4;

  typedef enum int {M_OFF, M_STEP, M_RUN} mode_e;

  logic clk = 1'b0;
  logic reset;

  mem_dump_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mem_dump_sequencer #(
    .ADDR_W   (ADDR_W),
    .DUMP_LO  (LO),
    .DUMP_HI  (HI),
    .AUTO_DIV (AUTO_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int strobe_cnt;
  int wrap_cnt;

  // Reference model: position as an offset within the window, plus step_in sample history
  mode_e m_mode  = M_OFF;
  int    m_pos   = 0;
  int    m_since = 0;
  bit    m_strobe, m_wrap;
  bit    h1, h2, h3;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_advance();
    m_strobe = 1'b1;
    if (bus.dir == 1'b0) begin
      m_wrap = (m_pos == SPAN - 1);
      m_pos  = (m_pos + 1) % SPAN;
    end else begin
      m_wrap = (m_pos == 0);
      m_pos  = (m_pos + SPAN - 1) % SPAN;
    end
  endtask

  task automatic model_edge();
    bit evt;
    evt      = h2 & ~h3;
    m_strobe = 1'b0;
    m_wrap   = 1'b0;
    if (!reset) begin
      m_mode = M_OFF; m_pos = 0; m_since = 0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      h3 = h2; h2 = h1; h1 = bus.step_in;
      if (!bus.enable) begin
        m_mode = M_OFF; m_pos = 0;
      end else if (m_mode == M_OFF) begin
        m_mode = bus.auto_mode ? M_RUN : M_STEP;
        m_pos = 0; m_since = 0; m_strobe = 1'b1;
      end else if (m_mode == M_STEP) begin
        if (bus.auto_mode) begin
          m_mode = M_RUN; m_since = 0;
        end else if (evt) begin
          model_advance();
        end
      end else begin
        if (!bus.auto_mode) begin
          m_mode = M_STEP;
        end else begin
          m_since++;
          if (m_since == AUTO_DIV) begin
            m_since = 0;
            model_advance();
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("addr",       32'(bus.addr),       32'(LO + 16'(m_pos)));
      check_eq("addr_valid", 32'(bus.addr_valid), 32'(m_mode != M_OFF));
      check_eq("rd_strobe",  32'(bus.rd_strobe),  32'(m_strobe));
      check_eq("wrap",       32'(bus.wrap),       32'(m_wrap));
      check_eq("busy",       32'(bus.busy),       32'(m_mode == M_RUN));
      strobe_cnt += int'(bus.rd_strobe);
      wrap_cnt   += int'(bus.wrap);
    end
  endtask

  task automatic step_pulse();
    bus.step_in = 1'b1;
    cyc(10);
    bus.step_in = 1'b0;
    cyc(10);
  endtask

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.step_in   = 1'b0;
    bus.auto_mode = 1'b0;
    bus.dir       = 1'b0;
    strobe_cnt    = 0;
    wrap_cnt      = 0;

    // Reset and entry into MANUAL
    cyc(3);
    check_eq("rst_addr", 32'(bus.addr), 32'h0010);
    check_eq("rst_valid", 32'(bus.addr_valid), 32'h0);
    reset      = 1'b1;
    bus.enable = 1'b1;
    cyc(1);
    check_eq("entry_strobe", 32'(bus.rd_strobe), 32'h1);
    check_eq("entry_valid", 32'(bus.addr_valid), 32'h1);
    cyc(1);
    check_eq("entry_strobe_off", 32'(bus.rd_strobe), 32'h0);

    // Manual up with wrap, then the exact two-edge step latency
    strobe_cnt = 0; wrap_cnt = 0;
    for (int i = 0; i < 4; i++) step_pulse();
    check_eq("up_strobes", 32'(strobe_cnt), 32'd4);
    check_eq("up_wraps", 32'(wrap_cnt), 32'd1);
    check_eq("up_addr", 32'(bus.addr), 32'h0010);
    bus.step_in = 1'b1;
    cyc(2);
    check_eq("lat_early", 32'(bus.rd_strobe), 32'h0);
    cyc(1);
    check_eq("lat_hit", 32'(bus.addr), 32'h0011);
    cyc(7);
    bus.step_in = 1'b0;
    cyc(10);

    // Manual down: back to 0x10, then wrap to 0x13 and on to 0x12
    bus.dir = 1'b1;
    step_pulse();
    check_eq("dn_lo", 32'(bus.addr), 32'h0010);
    step_pulse();
    check_eq("dn_wrap", 32'(bus.addr), 32'h0013);
    step_pulse();
    check_eq("dn_next", 32'(bus.addr), 32'h0012);
    step_pulse();
    step_pulse();

    // Auto-run from 0x10, step pulses must not add strobes
    bus.dir = 1'b0;
    bus.auto_mode = 1'b1;
    cyc(1);
    check_eq("auto_busy", 32'(bus.busy), 32'h1);
    strobe_cnt = 0; wrap_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      bus.step_in = (i % 2 == 0);
      cyc(4);
    end
    bus.step_in = 1'b0;
    check_eq("auto_strobes", 32'(strobe_cnt), 32'd4);
    check_eq("auto_wraps", 32'(wrap_cnt), 32'd1);

    // Priority: enable falls on the step-event edge
    bus.auto_mode = 1'b0;
    cyc(3);
    bus.step_in = 1'b1;
    cyc(2);
    bus.enable = 1'b0;
    cyc(1);
    check_eq("prio_step_strobe", 32'(bus.rd_strobe), 32'h0);
    check_eq("prio_step_valid", 32'(bus.addr_valid), 32'h0);
    bus.step_in = 1'b0;
    cyc(3);

    // Priority: enable falls on the terminal tick
    bus.enable = 1'b1;
    bus.auto_mode = 1'b1;
    cyc(4);
    bus.enable = 1'b0;
    cyc(1);
    check_eq("prio_tick_strobe", 32'(bus.rd_strobe), 32'h0);
    check_eq("prio_tick_addr", 32'(bus.addr), 32'h0010);

    // Reset mid-AUTO, re-entry through IDLE
    bus.enable = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check_eq("rst_auto_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    cyc(1);
    check_eq("reentry_strobe", 32'(bus.rd_strobe), 32'h1);
    cyc(4);
    check_eq("reentry_first_adv", 32'(bus.addr), 32'h0011);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)   bus.step_in   = ~bus.step_in;
      if ($urandom_range(0, 39) == 0)  bus.auto_mode = ~bus.auto_mode;
      if ($urandom_range(0, 9) == 0)   bus.dir       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0)  bus.enable    = ~bus.enable;
      reset = ($urandom_range(0, 249) != 0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dump_sequencer.md
Name: mem_dump_sequencer

Overview:
- Generates the RAM read address during memory-dump mode, upstream of the dump/processor address mux that feeds the RAM and the display.
- Replaces the free-running step counter with a bounded sequencer that supports manual stepping, auto-run and up/down direction.
- Emits a one-cycle strobe whenever the dump address changes, so downstream display logic can latch the new RAM word.

Parameters:
ADDR_W, 16, width of dump address
DUMP_LO, 16'h0000, first address of dump window (inclusive)
DUMP_HI, 16'h00FF, last address of dump window (inclusive); DUMP_HI >= DUMP_LO
AUTO_DIV, 25_000_000, clk cycles between auto-run steps; must be >= 2

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  dump mode request (dump_mem switch level)
step_in  in  1  debounced step level, asynchronous to clk
auto_mode  in  1  1 = auto-run, 0 = manual step
dir  in  1  0 = increment, 1 = decrement
addr  out  ADDR_W  current dump address (registered)
addr_valid  out  1  high while sequencer owns the address (state != IDLE)
rd_strobe  out  1  one-cycle pulse in the cycle a new addr first appears
wrap  out  1  one-cycle pulse coincident with rd_strobe when addr wrapped
busy  out  1  high in AUTO state

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, addr=DUMP_LO, addr_valid=0, rd_strobe=0, wrap=0, busy=0, tick counter=0, synchronizer flops=0. Reset overrides every other input.
- step_in synchronization: three flops s1->s2->s3. step_evt = s2 & ~s3 (combinational).
  - step_in first sampled high at edge N -> addr updates at edge N+2.
  - A held-high step produces exactly one event.
- States: IDLE, MANUAL, AUTO.
  - IDLE: addr held at DUMP_LO, addr_valid=0.
    - enable=1 -> MANUAL if auto_mode=0, else AUTO; addr=DUMP_LO, rd_strobe=1, tick counter cleared.
  - MANUAL: step_evt advances addr by one in dir; rd_strobe=1 that cycle.
    - auto_mode=1 -> AUTO with tick counter cleared; no address change on the switch cycle.
  - AUTO: tick counter counts 0..AUTO_DIV-1. At terminal count it wraps to 0 and addr advances; rd_strobe=1.
    - step_evt is ignored.
    - auto_mode=0 -> MANUAL; address is held.
  - Any state with enable=0 -> IDLE next edge; addr=DUMP_LO, addr_valid=0, no strobe. enable has priority over step/tick in the same cycle.
- Advance arithmetic:
  - Up: if addr==DUMP_HI, addr=DUMP_LO and wrap=1; else addr+1.
  - Down: if addr==DUMP_LO, addr=DUMP_HI and wrap=1; else addr-1.
  - Never leaves [DUMP_LO, DUMP_HI]; no modular ADDR_W overflow is possible.
  - DUMP_LO==DUMP_HI: every advance yields the same addr, with rd_strobe=1 and wrap=1.
- dir is sampled in the advance cycle; changing dir between steps is legal.
- rd_strobe and wrap are registered and never high for more than one consecutive cycle, except in AUTO with AUTO_DIV=... (AUTO_DIV>=2 guarantees a gap).
- Reset asserted mid-operation: all state is discarded and the block returns to reset values at that edge. After release it re-enters MANUAL/AUTO only via IDLE with enable=1.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_MANUAL=2'd1, ST_AUTO=2'd2;
  - DUMP_LO/DUMP_HI defaults shared with the top level.
- One sub-module: step_sync_edge (3-flop synchronizer plus rising-edge pulse, same clk/reset). Reused for any future button inputs.
- The top-level dump/processor mux selects addr when addr_valid=1.

Test Plan:
All scenarios use DUMP_LO=16'h0010, DUMP_HI=16'h0013, AUTO_DIV=4.
- Reset/entry: hold reset=0 for 3 cycles -> addr=0x0010, addr_valid=0, all pulses 0. Release, enable=1, auto_mode=0 -> next edge addr_valid=1, rd_strobe one cycle, addr=0x0010.
- Manual up with wrap: 4 step_in pulses (each 10 cycles high) -> addr 0x11, 0x12, 0x13, 0x10. Wrap=1 only on the 0x10 strobe. Each update occurs 2 edges after step_in is first sampled. Exactly one strobe per pulse.
- Manual down: dir=1 at addr=0x0010, one step -> addr=0x0013, wrap=1. Next step -> 0x0012, wrap=0.
- Auto-run: auto_mode=1 from addr 0x0010 -> busy=1, rd_strobe every 4 cycles. Sequence 0x11, 0x12, 0x13, 0x10. step_in pulses during AUTO cause no extra strobes.
- Priority: enable falls in the same cycle as a step event / terminal tick -> next edge state IDLE, addr=0x0010, addr_valid=0, rd_strobe=0.
- Reset mid-AUTO: reset=0 at tick 2 of 4 -> addr=0x0010, busy=0, tick counter=0. Release with enable=1, auto_mode=1 -> IDLE then AUTO. First auto advance occurs 4 cycles after entry strobe.
